// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small op-decode helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// sign-correcting results.
module md_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val_c
);

  assign o_val_c = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// One shift-add or restoring-divide step per clock, WIDTH steps per operation.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi_acc;
  logic [WIDTH-1:0]   r_lo_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_is_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_last;
  logic               w_ge;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_it_hi;
  logic [WIDTH-1:0]   w_it_lo;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = op_is_signed(op);
  assign w_is_div = op_is_div(op);
  assign w_neg_a  = w_signed & srca[WIDTH-1];
  assign w_neg_b  = w_signed & srcb[WIDTH-1];
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  md_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.i_neg(w_neg_a), .i_val(srca), .o_val_c(w_mag_a));
  md_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.i_neg(w_neg_b), .i_val(srcb), .o_val_c(w_mag_b));

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    w_sum   = {1'b0, r_hi_acc} + ({(WIDTH + 1){r_lo_acc[0]}} & {1'b0, r_opnd});
    w_shift = {r_hi_acc, r_lo_acc[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opnd};
    w_ge    = ~w_diff[WIDTH];
    w_it_hi = w_sum[WIDTH:1];
    w_it_lo = {w_sum[0], r_lo_acc[WIDTH-1:1]};
    if (r_is_div) begin
      w_it_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_it_lo = {r_lo_acc[WIDTH-2:0], w_ge};
    end
  end

  md_sign_fix #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .i_neg  (r_neg_res),
    .i_val  ({w_it_hi, w_it_lo}),
    .o_val_c(w_prod)
  );
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.i_neg(r_neg_res), .i_val(w_it_lo), .o_val_c(w_quo));
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.i_neg(r_neg_rem), .i_val(w_it_hi), .o_val_c(w_rem));

  assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CALC;
      ST_CALC: if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath, HI/LO and done pulse. A zero divisor needs only the quotient
  // sign suppressed: the restoring loop then yields all-ones and |srca|,
  // and the remainder sign fix restores the original dividend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
      r_hi_acc  <= '0;
      r_lo_acc  <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= (r_state == ST_CALC) && w_last;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_cnt     <= '0;
          r_is_div  <= w_is_div;
          r_neg_res <= (w_neg_a ^ w_neg_b) & ~(w_is_div & (srcb == '0));
          r_neg_rem <= w_is_div & w_neg_a;
          r_hi_acc  <= '0;
          r_lo_acc  <= w_is_div ? w_mag_a : w_mag_b;
          r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
        end else begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
        end
      end else begin
        r_cnt    <= r_cnt + CNT_W'(1);
        r_hi_acc <= w_it_hi;
        r_lo_acc <= w_it_lo;
        if (w_last) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end
    end
  end

  assign busy = (r_state == ST_CALC);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .srca   (srca),
    .srcb   (srcb),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference: 64-bit host arithmetic; SV division truncates toward zero so the
  // remainder already carries the dividend's sign.
  function automatic void model(input logic [1:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] m_hi, output logic [W-1:0] m_lo);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_hi = '0;
    m_lo = '0;
    case (m_op)
      2'b00: begin p = sa * sb; u = 64'(p); m_hi = u[63:32]; m_lo = u[31:0]; end
      2'b01: begin u = 64'(a) * 64'(b); m_hi = u[63:32]; m_lo = u[31:0]; end
      2'b10: begin
        if (b == '0) begin m_hi = a; m_lo = '1; end
        else begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
      end
      default: begin
        if (b == '0) begin m_hi = a; m_lo = '1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'(-int'($urandom_range(1, 20)));
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, optionally poking start / MTLO mid-flight, and check
  // busy length, single done pulse and the HI/LO result.
  task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit mid_start, input bit mid_lo);
    int cyc;
    bit early_done;
    model(t_op, a, b, exp_hi, exp_lo);
    @(negedge clk);
    start = 1'b1; op = t_op; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; srca = $urandom; srcb = $urandom;
    cyc = 0;
    early_done = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin
      start = 1'b0;
      lo_we = 1'b0;
      if (done !== 1'b0) early_done = 1'b1;
      cyc++;
      if (cyc == 5 && mid_start) begin start = 1'b1; op = t_op ^ 2'b10; srca = $urandom; srcb = $urandom; end
      if (cyc == 5 && mid_lo) begin lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      @(negedge clk);
    end
    start = 1'b0;
    lo_we = 1'b0;
    check_eq({tag, ".busy_cycles"}, 32'(cyc), 32'(W));
    check_eq({tag, ".early_done"}, 32'(early_done), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".hi"}, hi, exp_hi);
    check_eq({tag, ".lo"}, lo, exp_lo);
    @(negedge clk);
    check_eq({tag, ".done_pulse_end"}, 32'(done), 32'd0);
    check_eq({tag, ".busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("reset.busy", 32'(busy), 32'd0);
    check_eq("reset.done", 32'(done), 32'd0);
    check_eq("reset.hi", hi, 32'd0);
    check_eq("reset.lo", lo, 32'd0);
    reset_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0, 1'b0);
    check_eq("multu_max.hi_const", hi, 32'hFFFF_FFFE);
    check_eq("multu_max.lo_const", lo, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b0, 1'b0);
    check_eq("mult_neg.lo_const", lo, 32'hFFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0, 1'b0);
    check_eq("div_neg.lo_const", lo, 32'hFFFF_FFFD);
    check_eq("div_neg.hi_const", hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, 1'b0);
    check_eq("div_ovf.lo_const", lo, 32'h8000_0000);
    run_op(2'b11, 32'd100, 32'd0, "divu_by0", 1'b0, 1'b0);
    check_eq("divu_by0.hi_const", hi, 32'h0000_0064);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd0, "div_by0_neg", 1'b0, 1'b0);

    // MTHI in IDLE, then both enables together.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi.hi", hi, 32'h1234_5678);
    check_eq("mthi.lo_kept", lo, exp_lo);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check_eq("mthilo.hi", hi, 32'hA5A5_0F0F);
    check_eq("mthilo.lo", lo, 32'hA5A5_0F0F);

    run_op(2'b11, 32'd1000, 32'd7, "mtlo_in_calc", 1'b0, 1'b1);
    run_op(2'b01, 32'd123456, 32'd789, "restart_in_calc", 1'b1, 1'b0);

    // Reset during iteration 10 of a DIVU discards the operation.
    @(negedge clk);
    start = 1'b1; op = 2'b11; srca = 32'hFFFF_0000; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid.busy", 32'(busy), 32'd0);
    check_eq("rst_mid.hi", hi, 32'd0);
    check_eq("rst_mid.lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (W) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) begin
        check_eq("rst_mid.no_done", {30'd0, done, busy}, 32'd0);
      end
    end
    check_eq("rst_mid.done_after", 32'(done), 32'd0);
    check_eq("rst_mid.hi_after", hi, 32'd0);
    run_op(2'b01, 32'd5, 32'd6, "multu_after_rst", 1'b0, 1'b0);
    check_eq("multu_after_rst.lo_const", lo, 32'd30);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   r_op;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      r_op = 2'($urandom_range(0, 3));
      ra = pick_val();
      rb = pick_val();
      run_op(r_op, ra, rb, $sformatf("rand%0d_op%0d", i, r_op), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit sitting directly downstream of the register file.
- Consumes the two read-port values (rd1/rd2) for MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- hi/lo outputs feed the MFHI/MFLO path back to the register file's write-data port (wd3).
- The controller stalls on busy; MTHI/MTLO write HI/LO directly.

Parameters:
WIDTH, 32, operand/result width; must be even and ≥4; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
clk  input  1  clock, rising-edge active.
reset_n  input  1  asynchronous active-low reset.
start  input  1  begin operation; sampled only in IDLE.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
srca  input  WIDTH  operand A (rs value / dividend / multiplicand).
srcb  input  WIDTH  operand B (rt value / divisor / multiplier).
hi_we  input  1  MTHI write enable.
lo_we  input  1  MTLO write enable.
wdata  input  WIDTH  data for MTHI/MTLO.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when HI/LO have been updated by an operation.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Asynchronous reset while reset_n=0:
  - state=IDLE; hi=0, lo=0, done=0, busy=0; counter and datapath registers cleared.
  - Applies mid-operation too: the result is discarded.
- States: IDLE, CALC.
  - busy = (state==CALC), combinational from state.
  - done is a registered one-cycle pulse.
- IDLE, start=1 at edge N:
  - Latch op, sign flags, |srca|, |srcb|. Signed ops take two's-complement magnitude; unsigned ops take the raw value.
  - Counter=0; go to CALC. busy is high from cycle N+1.
- CALC: one iteration per edge, WIDTH iterations in total (edges N+1..N+WIDTH).
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per edge.
- Edge N+WIDTH:
  - hi/lo written with the sign-corrected result; state back to IDLE.
  - done=1 during cycle N+WIDTH+1 only.
  - Total latency is WIDTH+1 edges from the start edge to hi/lo valid.
- Sign rules:
  - MULT: product negated when exactly one operand is negative.
  - DIV: quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - MULT/MULTU: hi = upper WIDTH bits, lo = lower WIDTH bits.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero: same latency; lo = all ones, hi = dividend (original srca, unmodified).
- DIV overflow (most-negative / -1): lo = 0x80000000, hi = 0 (natural wrap, no trap).
- start while busy: ignored, with no effect on the operation in flight.
- hi_we/lo_we:
  - Write hi/lo at the edge, only in IDLE.
  - Ignored in CALC; the operation result always wins.
  - Simultaneous start and hi_we/lo_we in IDLE: start accepted, MTHI/MTLO write dropped. The controller must not issue both.
  - hi_we and lo_we together: both registers take wdata.
- hi/lo hold their values at all other times. Outputs are direct register outputs with no combinational path from inputs.
- op values are fully decoded; no illegal encodings.

Decomposition:
- Shared package (mips_pkg): op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11) and state encodings (ST_IDLE, ST_CALC).
- One natural sub-module, md_sign_fix: combinational conditional two's-complement negate of a WIDTH-bit value. Used for input magnitude and result correction, instantiated as needed.
- Iteration datapath stays in the top module.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy high for exactly 32 cycles.
  - done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 × 7: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV overflow and divide by zero:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 100 / 0 → lo=0xFFFFFFFF, hi=0x00000064, with normal latency.
- MTHI/MTLO and start interactions:
  - MTHI 0x12345678 in IDLE → hi=0x12345678 next cycle.
  - MTLO during CALC → ignored; lo equals the operation result.
  - Second start during busy → ignored; only one done pulse.
- Reset mid-operation:
  - Deassert reset_n at iteration 10 of a DIVU → hi=lo=0, busy=0, no done pulse.
  - After release, a fresh MULTU 5×6 gives lo=30, hi=0.
